uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Standalone UART receiver with a byte FIFO. It is the far-end peer of the team's UART transmitter.
- Deserialises 8N1 frames from the serial line and buffers them for a valid/ready consumer.
- Drives a hardware flow-control output whose polarity matches the transmitter's CTS input: low means the peer may send.
- Sits between the board UART RX pin and a CPU or DMA byte consumer.

Parameters:
- BAUD_DIV, 217, clock cycles per bit. Legal range is 4 or more.
- FIFO_DEPTH, 8, RX FIFO entries. Must be a power of 2, 2 or more.
- RTS_MARGIN, 2, free entries left when UART_RTS deasserts. Legal range is 1 to FIFO_DEPTH-1.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- UART_RX  in  1  serial line. Asynchronous; idle high.
- UART_RTS  out  1  to the peer's CTS. 0 = send allowed, 1 = stop.
- rx_data  out  8  head-of-FIFO byte. First-word fall-through.
- rx_valid  out  1  FIFO not empty.
- rx_ready  in  1  consumer pop. A pop occurs when rx_valid && rx_ready.
- rx_count  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy.
- frame_err  out  1  sticky: a stop bit was sampled as 0.
- overrun_err  out  1  sticky: a byte was dropped because the FIFO was full.
- err_clr  in  1  pulse; clears both sticky flags.

Behaviour:
- Reset values: FIFO empty, rx_valid=0, rx_data=0, rx_count=0, frame_err=0, overrun_err=0, UART_RTS=0.
  - Synchroniser flops reset to 1.
  - FSM resets to WAIT_IDLE.
- Input sync: UART_RX passes through a 2-flop synchroniser to give rx_s (2 cycles latency). The FSM uses only rx_s.
- Bit counter: bit_cnt counts 0..BAUD_DIV-1. HALF = floor(BAUD_DIV/2).
- FSM states:
  - WAIT_IDLE: go to IDLE when rx_s==1. This rejects a line held low after reset or break.
  - IDLE: when rx_s==0, go to START with bit_cnt=0.
  - START: at bit_cnt==HALF-1, sample rx_s.
    - rx_s==1: false start; go to IDLE.
    - rx_s==0: bit_cnt=0, bit index=0, go to DATA.
  - DATA: at bit_cnt==BAUD_DIV-1, shift rx_s in LSB first (first received bit ends up in bit 0) and increment the bit index. After the 8th bit, go to STOP.
  - STOP: at bit_cnt==BAUD_DIV-1, sample rx_s.
    - rx_s==1: push the byte and go to IDLE.
    - rx_s==0: discard the byte, set frame_err, go to WAIT_IDLE.
- Push timing: a push writes on the same edge that samples the stop bit. rx_valid rises on the next cycle when the FIFO was empty.
- Overrun: a push when count==FIFO_DEPTH with no simultaneous pop drops the byte and sets overrun_err. FIFO contents are unchanged.
  - Push and pop in the same cycle while full: both occur; count stays at FIFO_DEPTH.
- FIFO: circular read/write pointers wrap modulo FIFO_DEPTH.
  - rx_data = mem[rptr], and is 0 when empty.
  - Pop when empty is ignored.
  - Push and pop in the same cycle with count in 1..FIFO_DEPTH-1 leaves count unchanged.
- UART_RTS: registered. Value is (count_next >= FIFO_DEPTH-RTS_MARGIN), so it updates 1 cycle after the push/pop that causes the change.
  - Frames already in flight are still received; the margin absorbs them.
- Errors: err_clr clears both flags. If an error event and err_clr occur in the same cycle, the set wins.
- Reset mid-frame: the partial byte is lost, the FIFO empties, and the FSM returns to WAIT_IDLE.

Test Plan (BAUD_DIV=16, FIFO_DEPTH=4, RTS_MARGIN=1):
- Idle reset, then frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> rx_valid=1 one cycle after the stop sample; rx_data=0xA5; rx_count=1; both error flags 0. Pop with rx_ready -> rx_valid=0.
- Low glitch of 5 cycles on the line -> START aborts at the HALF sample; no push; FSM back in IDLE.
- Frame 0x3C with stop bit 0, line then held low 40 cycles, then high, then frame 0x11 -> frame_err=1, 0x3C not stored; 0x11 received correctly. err_clr -> frame_err=0.
- Send 0x01, 0x02, 0x03 with no pops -> UART_RTS=1 one cycle after the third push (count 3 >= 3). Send 0x04 -> count=4. Send 0x05 -> overrun_err=1, FIFO holds 01,02,03,04. Pop one -> UART_RTS=0.
- FIFO full; pop asserted in the same cycle as the stop sample of 0x55 -> no overrun; count stays 4; FIFO order is 02,03,04,55 (pointer wrap checked).
- Assert rst during DATA of a frame, release with the line still low -> no byte pushed, rx_count=0. The next full frame after the line returns high is received correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with a first-word fall-through byte FIFO, sticky
// framing/overrun flags and an RTS flow-control output for the peer's CTS.
module uart_rx_fifo #(
  parameter int BAUD_DIV   = 217,
  parameter int FIFO_DEPTH = 8,
  parameter int RTS_MARGIN = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            UART_RX,
  output logic                            UART_RTS,
  output logic [7:0]                      rx_data,
  output logic                            rx_valid,
  input  logic                            rx_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] rx_count,
  output logic                            frame_err,
  output logic                            overrun_err,
  input  logic                            err_clr
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] BIT_END = CW'(BAUD_DIV - 1);
  localparam logic [NW-1:0] DEPTH_N = NW'(FIFO_DEPTH);
  localparam logic [NW-1:0] RTS_LVL = NW'(FIFO_DEPTH - RTS_MARGIN);

  typedef enum logic [2:0] {
    WAIT_IDLE = 3'd0,
    IDLE      = 3'd1,
    START     = 3'd2,
    DATA      = 3'd3,
    STOP      = 3'd4
  } rx_state_t;

  rx_state_t       state, state_n;
  logic [1:0]      sync_q;
  logic            rx_s;
  logic [CW-1:0]   cnt, cnt_n;
  logic [2:0]      idx, idx_n;
  logic [7:0]      sh, sh_n;
  logic            push, ferr_set;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   rptr, wptr;
  logic [NW-1:0]   count, count_n;
  logic            full, do_push, do_pop, ovr_set;

  // Two-flop synchroniser for the asynchronous serial line; idles high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], UART_RX};
  end
  assign rx_s = sync_q[1];

  // Receiver state, bit timer, bit index and shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= WAIT_IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      sh    <= sh_n;
    end
  end

  // Frame decoding: start is re-checked at half a bit, data and stop are
  // sampled one full bit period apart from there.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt + CW'(1);
    idx_n    = idx;
    sh_n     = sh;
    push     = 1'b0;
    ferr_set = 1'b0;
    case (state)
      WAIT_IDLE: begin
        cnt_n = '0;
        if (rx_s) state_n = IDLE;
      end
      IDLE: begin
        cnt_n = '0;
        if (!rx_s) state_n = START;
      end
      START: begin
        if (cnt == HALF_M1) begin
          cnt_n = '0;
          if (rx_s) begin
            state_n = IDLE;
          end else begin
            idx_n   = '0;
            state_n = DATA;
          end
        end
      end
      DATA: begin
        if (cnt == BIT_END) begin
          cnt_n = '0;
          sh_n  = {rx_s, sh[7:1]};
          idx_n = idx + 3'd1;
          if (idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (cnt == BIT_END) begin
          cnt_n = '0;
          if (rx_s) begin
            push    = 1'b1;
            state_n = IDLE;
          end else begin
            ferr_set = 1'b1;
            state_n  = WAIT_IDLE;
          end
        end
      end
      default: begin
        cnt_n   = '0;
        state_n = WAIT_IDLE;
      end
    endcase
  end

  // Consumer handshake: rx_valid means rx_data holds the oldest byte; a byte
  // is taken on any clock edge where rx_valid && rx_ready. rx_valid never
  // depends on rx_ready, and rx_data only changes after a pop or a push into
  // an empty FIFO.
  assign full     = (count == DEPTH_N);
  assign rx_valid = (count != '0);
  assign do_pop   = rx_valid && rx_ready;
  assign do_push  = push && (!full || do_pop);
  assign ovr_set  = push && full && !do_pop;
  assign rx_data  = rx_valid ? mem[rptr] : 8'h00;
  assign rx_count = count;

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_n = count;
    case ({do_push, do_pop})
      2'b10:   count_n = count + NW'(1);
      2'b01:   count_n = count - NW'(1);
      default: count_n = count;
    endcase
  end

  // FIFO storage; contents need no reset because empty forces rx_data to 0.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= sh;
  end

  // Pointers, occupancy and registered RTS threshold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr     <= '0;
      wptr     <= '0;
      count    <= '0;
      UART_RTS <= 1'b0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      count    <= count_n;
      UART_RTS <= (count_n >= RTS_LVL);
    end
  end

  // Sticky error flags; a new error event beats a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      if (ferr_set)     frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;
      if (ovr_set)      overrun_err <= 1'b1;
      else if (err_clr) overrun_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed vector table, hand-written corner
// sequences, then random frames checked against a transaction-level model.
module tb_uart_rx_fifo;

  localparam int BAUD  = 16;
  localparam int DEPTH = 4;
  localparam int MARG  = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       UART_RX = 1'b1;
  logic       UART_RTS;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic [2:0] rx_count;
  logic       frame_err;
  logic       overrun_err;
  logic       err_clr = 1'b0;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state.
  logic [7:0] exp_q[$];
  bit         mdl_fe;
  bit         mdl_ov;

  typedef struct {
    bit         do_frame;
    logic [7:0] data;
    bit         stop;
    int         low_after;
    int         npop;
    bit         clr;
    int         exp_cnt;
    logic [7:0] exp_head;
    bit         exp_fe;
    bit         exp_ov;
    bit         exp_rts;
  } vec_t;

  vec_t vecs[10];

  uart_rx_fifo #(.BAUD_DIV(BAUD), .FIFO_DEPTH(DEPTH), .RTS_MARGIN(MARG)) dut (
    .clk        (clk),
    .rst        (rst),
    .UART_RX    (UART_RX),
    .UART_RTS   (UART_RTS),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rx_count   (rx_count),
    .frame_err  (frame_err),
    .overrun_err(overrun_err),
    .err_clr    (err_clr)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    UART_RX = 1'b1;
    tick(n);
  endtask

  task automatic hold_low(input int n);
    UART_RX = 1'b0;
    tick(n);
  endtask

  task automatic pop_one();
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
  endtask

  // Drives one full 10-bit frame. The receiver samples the stop bit on the
  // 155th edge after the first drive; pop_at_stop holds rx_ready on that
  // edge, chk_lat checks rx_valid rises right after it (FIFO empty).
  task automatic send_frame(input logic [7:0] b, input bit stop, input bit pop_at_stop,
                            input bit chk_lat);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int c = 0; c < 10 * BAUD; c++) begin
      if (chk_lat && c == 154) chk("valid_before_stop", 32'(rx_valid), 32'd0);
      if (chk_lat && c == 155) chk("valid_after_stop", 32'(rx_valid), 32'd1);
      UART_RX  = bits[c / BAUD];
      rx_ready = pop_at_stop && (c == 154);
      tick(1);
    end
    rx_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    UART_RX = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(5);
  endtask

  task automatic check_outputs(input string tag, input int cnt, input logic [7:0] head,
                               input bit fe, input bit ov, input bit rts);
    chk({tag, "_count"}, 32'(rx_count), 32'(cnt));
    chk({tag, "_valid"}, 32'(rx_valid), 32'(cnt != 0));
    chk({tag, "_data"},  32'(rx_data), 32'(head));
    chk({tag, "_ferr"},  32'(frame_err), 32'(fe));
    chk({tag, "_ovr"},   32'(overrun_err), 32'(ov));
    chk({tag, "_rts"},   32'(UART_RTS), 32'(rts));
  endtask

  task automatic check_model(input string tag);
    logic [7:0] head;
    head = (exp_q.size() != 0) ? exp_q[0] : 8'h00;
    check_outputs(tag, exp_q.size(), head, mdl_fe, mdl_ov, exp_q.size() >= DEPTH - MARG);
  endtask

  initial begin
    // Directed table: {frame, stop, low hold, pops, clear} -> expected outputs.
    vecs[0] = '{1, 8'hA5, 1, 0,  0, 0, 1, 8'hA5, 0, 0, 0};
    vecs[1] = '{0, 8'h00, 1, 0,  1, 0, 0, 8'h00, 0, 0, 0};
    vecs[2] = '{1, 8'h3C, 0, 40, 0, 0, 0, 8'h00, 1, 0, 0};
    vecs[3] = '{1, 8'h11, 1, 0,  0, 0, 1, 8'h11, 1, 0, 0};
    vecs[4] = '{0, 8'h00, 1, 0,  1, 1, 0, 8'h00, 0, 0, 0};
    vecs[5] = '{1, 8'h01, 1, 0,  0, 0, 1, 8'h01, 0, 0, 0};
    vecs[6] = '{1, 8'h02, 1, 0,  0, 0, 2, 8'h01, 0, 0, 0};
    vecs[7] = '{1, 8'h03, 1, 0,  0, 0, 3, 8'h01, 0, 0, 1};
    vecs[8] = '{1, 8'h04, 1, 0,  0, 0, 4, 8'h01, 0, 0, 1};
    vecs[9] = '{1, 8'h05, 1, 0,  0, 0, 4, 8'h01, 0, 1, 1};

    // Reset state.
    tick(2);
    check_outputs("reset_hold", 0, 8'h00, 0, 0, 0);
    rst = 1'b0;
    tick(5);
    check_outputs("reset", 0, 8'h00, 0, 0, 0);

    // Short low glitch must abort at the half-bit start check.
    hold_low(5);
    idle(40);
    check_outputs("glitch", 0, 8'h00, 0, 0, 0);

    // Directed vectors.
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].do_frame) begin
        send_frame(vecs[i].data, vecs[i].stop, 1'b0, 1'b0);
        if (vecs[i].low_after > 0) hold_low(vecs[i].low_after);
        idle(6);
      end
      if (vecs[i].clr) pulse_clr();
      for (int p = 0; p < vecs[i].npop; p++) pop_one();
      idle(2);
      check_outputs($sformatf("vec%0d", i), vecs[i].exp_cnt, vecs[i].exp_head,
                    vecs[i].exp_fe, vecs[i].exp_ov, vecs[i].exp_rts);
    end

    // Full FIFO (01..04): pop on the same edge as the 0x55 stop sample.
    pulse_clr();
    chk("ovr_cleared", 32'(overrun_err), 32'd0);
    send_frame(8'h55, 1'b1, 1'b1, 1'b0);
    idle(4);
    check_outputs("full_pushpop", 4, 8'h02, 0, 0, 1);
    begin
      logic [7:0] order [4];
      order[0] = 8'h02; order[1] = 8'h03; order[2] = 8'h04; order[3] = 8'h55;
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("drain%0d_data", k), 32'(rx_data), 32'(order[k]));
        pop_one();
        tick(1);
        chk($sformatf("drain%0d_count", k), 32'(rx_count), 32'(3 - k));
        chk($sformatf("drain%0d_rts", k), 32'(UART_RTS), 32'((3 - k) >= DEPTH - MARG));
      end
    end
    chk("drain_pop_empty_data", 32'(rx_data), 32'h0);
    pop_one();
    chk("pop_empty_count", 32'(rx_count), 32'd0);

    // Reset in the middle of a frame with the line still low.
    for (int c = 0; c < 60; c++) begin
      UART_RX = 1'b0;
      tick(1);
    end
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);
    chk("midrst_count", 32'(rx_count), 32'd0);
    chk("midrst_valid", 32'(rx_valid), 32'd0);
    hold_low(200);
    chk("midrst_nopush", 32'(rx_count), 32'd0);
    pulse_clr();
    idle(10);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b1);
    idle(6);
    check_outputs("after_midrst", 1, 8'h5A, 0, 0, 0);

    // Random frames against the transaction-level model.
    do_reset();
    exp_q.delete();
    mdl_fe = 0;
    mdl_ov = 0;
    check_model("rand_start");
    for (int f = 0; f < 30; f++) begin
      logic [7:0] b;
      bit         stop;
      int         npop;
      b    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 5) != 0);
      npop = $urandom_range(0, 2);
      send_frame(b, stop, 1'b0, 1'b0);
      if (stop) begin
        if (exp_q.size() == DEPTH) mdl_ov = 1;
        else exp_q.push_back(b);
      end else begin
        mdl_fe = 1;
        hold_low(20);
      end
      idle($urandom_range(4, 12));
      check_model($sformatf("rand%0d_rx", f));
      if ($urandom_range(0, 4) == 0) begin
        pulse_clr();
        mdl_fe = 0;
        mdl_ov = 0;
      end
      for (int p = 0; p < npop; p++) begin
        if (exp_q.size() != 0) chk($sformatf("rand%0d_head", f), 32'(rx_data), 32'(exp_q[0]));
        pop_one();
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      idle(2);
      check_model($sformatf("rand%0d_pop", f));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
